// File: rtl/kgp_regs_pkg.sv
// kgp_regs_pkg: shared register-file constants and types.
//   Provides default widths, the hard-wired zero register, the link register ($ra)
//   and the address/data typedefs used by the destination path.
package kgp_regs_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS = 2 ** DEF_ADDR_W;
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [DEF_ADDR_W-1:0] REG_RA = 5'd31;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/dest_decoder_5to32.sv
// dest_decoder_5to32: register address to one-hot select, gated by enable.
//   en     in  1            decode enable; all-zero output when low
//   addr   in  ADDR_W       register address
//   onehot out 2**ADDR_W    one-hot select (bit addr set when en)
module dest_decoder_5to32 import kgp_regs_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);
  localparam int N = 2 ** ADDR_W;
  always_comb onehot = en ? ({{(N-1){1'b0}}, 1'b1} << addr) : '0;
endmodule

// File: rtl/regfile_dest_writeback.sv
// regfile_dest_writeback: 32x32 register file write-back with busy scoreboard.
//   clk, rst (sync, active-low)
//   rs_addr/rt_addr -> rs_data/rt_data, busy_rs/busy_rt : combinational read ports
//   wr_en/wr_addr/wr_data : write-back; clears busy[wr_addr]
//   resv_en/resv_addr     : reservation; sets busy[resv_addr] (wins over clear)
//   busy_vec              : registered scoreboard
//   Option REGFILE_BYPASS_EN: same-cycle write-through on both read ports.
module regfile_dest_writeback import kgp_regs_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    rs_addr,
  input  logic [ADDR_W-1:0]    rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 resv_en,
  input  logic [ADDR_W-1:0]    resv_addr,
  output logic                 busy_rs,
  output logic                 busy_rt,
  output logic [2**ADDR_W-1:0] busy_vec
);
  localparam int N = 2 ** ADDR_W;
  localparam logic [N-1:0] NZ_MASK = {{(N-1){1'b1}}, 1'b0};
  logic [DATA_W-1:0] regs [N];
  logic [N-1:0] wr_oh, resv_oh;
  dest_decoder_5to32 #(.ADDR_W(ADDR_W)) u_wr_dec (.en(wr_en), .addr(wr_addr), .onehot(wr_oh));
  dest_decoder_5to32 #(.ADDR_W(ADDR_W)) u_resv_dec (.en(resv_en), .addr(resv_addr), .onehot(resv_oh));
  // Register 0 is never written and never reserved, so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy_vec <= '0;
    end else begin
      for (int i = 1; i < N; i++) if (wr_oh[i]) regs[i] <= wr_data;
      busy_vec <= ((busy_vec & ~wr_oh) | resv_oh) & NZ_MASK;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic wr_live, byp_rs, byp_rt, resv_hit;
  always_comb begin
    wr_live = rst && wr_en && wr_addr != '0;
    byp_rs = wr_live && rs_addr == wr_addr;
    byp_rt = wr_live && rt_addr == wr_addr;
    resv_hit = resv_en && resv_addr == wr_addr;
    rs_data = byp_rs ? wr_data : regs[rs_addr];
    rt_data = byp_rt ? wr_data : regs[rt_addr];
    busy_rs = busy_vec[rs_addr] && !(byp_rs && !resv_hit);
    busy_rt = busy_vec[rt_addr] && !(byp_rt && !resv_hit);
  end
`else
  always_comb begin
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    busy_rs = busy_vec[rs_addr];
    busy_rt = busy_vec[rt_addr];
  end
`endif
endmodule

// File: tb/tb_regfile_dest_writeback.sv
// tb_regfile_dest_writeback: directed scoreboard bench for regfile_dest_writeback.
module tb_regfile_dest_writeback;
  logic clk = 0, rst = 0;
  logic [4:0] rs_addr = 0, rt_addr = 0, wr_addr = 0, resv_addr = 0;
  logic [31:0] rs_data, rt_data, wr_data = 0, busy_vec;
  logic wr_en = 0, resv_en = 0, busy_rs, busy_rt;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1;
`else
  localparam bit BYP = 0;
`endif
  regfile_dest_writeback dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .resv_en(resv_en), .resv_addr(resv_addr),
    .busy_rs(busy_rs), .busy_rt(busy_rt), .busy_vec(busy_vec)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got=%h expected=<scoreboard empty>", tag, got);
    end else chk(tag, got, exp_q.pop_front());
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; resv_en = re; resv_addr = ra;
  endtask
  initial begin
    rs_addr = 5; rt_addr = 3;
    drive(1, 5, 32'hAAAA_AAAA, 1, 3);
    tick(); tick();
    push(0); push(0); push(0);
    pop_chk("rst_rs", rs_data);
    pop_chk("rst_rt", rt_data);
    pop_chk("rst_busy", busy_vec);
    rst = 1; drive(0, 0, 0, 0, 0);
    tick();
    push(0); push(0);
    pop_chk("rst_nowrite", rs_data);
    pop_chk("rst_busy2", busy_vec);
    rs_addr = 1;
    drive(1, 5, 32'hDEAD_BEEF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0); rs_addr = 5; rt_addr = 5; #1;
    push(32'hDEAD_BEEF); push(32'hDEAD_BEEF);
    pop_chk("wr5_rs", rs_data);
    pop_chk("wr5_rt_same", rt_data);
    rt_addr = 0;
    drive(1, 0, 32'hFFFF_FFFF, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    push(0); push(0);
    pop_chk("r0_rt", rt_data);
    pop_chk("r0_busy", {31'b0, busy_vec[0]});
    drive(0, 0, 0, 1, 31);
    tick();
    push(1);
    pop_chk("resv31", {31'b0, busy_vec[31]});
    drive(1, 31, 32'h3131_3131, 1, 7);
    tick();
    push(32'h0000_0080);
    pop_chk("clr31_set7", busy_vec);
    drive(1, 7, 32'h7777_7777, 1, 7);
    tick();
    drive(0, 0, 0, 0, 0); rs_addr = 7; #1;
    push(1); push(32'h7777_7777); push(1);
    pop_chk("setwins_busy7", {31'b0, busy_vec[7]});
    pop_chk("setwins_data7", rs_data);
    pop_chk("busy_rs7", {31'b0, busy_rs});
    drive(1, 7, 32'h8888_8888, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0); #1;
    push(0); push(32'h8888_8888);
    pop_chk("wr7_clear", {31'b0, busy_vec[7]});
    pop_chk("wr7_data", rs_data);
    drive(1, 9, 32'h5555, 1, 9);
    tick();
    drive(1, 9, 32'h1234, 0, 0); rs_addr = 9; rt_addr = 9; #1;
    push(BYP ? 32'h1234 : 32'h5555); push(BYP ? 0 : 1); push(BYP ? 0 : 1);
    pop_chk("byp_rs", rs_data);
    pop_chk("byp_busy_rs", {31'b0, busy_rs});
    pop_chk("byp_busy_rt", {31'b0, busy_rt});
    tick();
    drive(0, 0, 0, 0, 0); #1;
    push(32'h1234); push(0);
    pop_chk("wr9_after", rs_data);
    pop_chk("wr9_busy", {31'b0, busy_rs});
    drive(1, 3, 32'h3333, 1, 4);
    tick();
    drive(0, 0, 0, 1, 3);
    tick();
    drive(0, 0, 0, 0, 0); rs_addr = 3; #1;
    push(32'h0000_0018); push(32'h3333);
    pop_chk("resv34", busy_vec);
    pop_chk("reg3_pre", rs_data);
    rst = 0;
    tick();
    push(0); push(0);
    pop_chk("midrst_busy", busy_vec);
    pop_chk("midrst_reg3", rs_data);
    rst = 1;
    tick();
    push(0);
    pop_chk("post_rst_busy", busy_vec);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got=%0d leftover expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
